// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: BCD stopwatch/countdown core; in clk/reset/start/stop/clear/load/load_value/up, out digits/running/tick/carry_out/expired
module bcd_timer_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10,
  parameter int WRAP     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  tick,
  output logic                  carry_out,
  output logic                  expired
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'h9}};
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [4*DIGITS-1:0] dig_q, dig_d, stepped, sat;
  logic tick_q, tick_d, co_q, co_d;
  logic term, post_term, fin;
  always_comb begin : arith
    logic en;
    logic [3:0] nib, lv;
    en = 1'b1;
    stepped = '0;
    sat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = dig_q[4*i +: 4];
      lv = load_value[4*i +: 4];
      stepped[4*i +: 4] = !en ? nib : up ? (nib == 4'd9 ? 4'd0 : nib + 4'd1) : (nib == 4'd0 ? 4'd9 : nib - 4'd1);
      en = en & (up ? nib == 4'd9 : nib == 4'd0);
      sat[4*i +: 4] = lv > 4'd9 ? 4'd9 : lv;
    end
  end
  assign term      = up ? dig_q == ALL9 : dig_q == '0;
  assign post_term = up ? stepped == ALL9 : stepped == '0;
  assign fin       = term | post_term;
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    dig_d   = dig_q;
    tick_d  = 1'b0;
    co_d    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      pre_d   = '0;
      dig_d   = '0;
    end else if (load) begin
      dig_d   = sat;
      pre_d   = '0;
      state_d = (state_q == RUN || state_q == PAUSED) ? state_q : IDLE;
    end else if (stop && state_q == RUN) begin
      state_d = PAUSED;
    end else if (start && (state_q == IDLE || state_q == PAUSED)) begin
      state_d = RUN;
    end else if (state_q == RUN && pre_q != LAST) begin
      pre_d = pre_q + 1'b1;
    end else if (state_q == RUN && !start) begin
      // step cycle: a start seen here is still a command and holds the step off
      tick_d = 1'b1;
      pre_d  = '0;
      if (WRAP != 0) begin
        dig_d = stepped;
        co_d  = term;
      end else begin
        dig_d   = term ? dig_q : stepped;
        co_d    = fin;
        state_d = fin ? DONE : RUN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      dig_q   <= '0;
      tick_q  <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
      co_q    <= co_d;
    end
  end
  assign digits    = dig_q;
  assign running   = state_q == RUN;
  assign expired   = state_q == DONE;
  assign tick      = tick_q;
  assign carry_out = co_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed and random checks of bcd_timer_ctrl (WRAP=0 and WRAP=1) against a decimal model
module tb_bcd_timer_ctrl;
  localparam int P = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, up = 1'b1;
  logic [7:0] load_value = '0;
  logic [7:0] dg [2];
  logic rn [2], tk [2], co [2], ex [2];
  int total = 0, bad = 0;
  int mst [2], mval [2], mpre [2];
  bit mtk [2], mco [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(P), .WRAP(g)) u_dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
      .load_value(load_value), .up(up), .digits(dg[g]), .running(rn[g]), .tick(tk[g]),
      .carry_out(co[g]), .expired(ex[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int sat_val(input logic [7:0] v);
    int t, o;
    t = v[7:4] > 4'd9 ? 9 : int'(v[7:4]);
    o = v[3:0] > 4'd9 ? 9 : int'(v[3:0]);
    return t * 10 + o;
  endfunction
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction
  task automatic model_step();
    for (int w = 0; w < 2; w++) begin
      mtk[w] = 0;
      mco[w] = 0;
      if (reset) begin
        mst[w] = S_IDLE; mval[w] = 0; mpre[w] = 0;
      end else if (clear) begin
        mst[w] = S_IDLE; mval[w] = 0; mpre[w] = 0;
      end else if (load) begin
        mval[w] = sat_val(load_value);
        mpre[w] = 0;
        if (mst[w] == S_DONE) mst[w] = S_IDLE;
      end else if (stop && mst[w] == S_RUN) begin
        mst[w] = S_PAUSE;
      end else if (start && (mst[w] == S_IDLE || mst[w] == S_PAUSE)) begin
        mst[w] = S_RUN;
      end else if (mst[w] == S_RUN) begin
        if (mpre[w] < P - 1) mpre[w]++;
        else if (!start) begin
          bit term;
          term = up ? mval[w] == 99 : mval[w] == 0;
          mtk[w] = 1;
          mpre[w] = 0;
          if (w == 1) begin
            mval[w] = up ? (mval[w] + 1) % 100 : (mval[w] + 99) % 100;
            mco[w] = term;
          end else begin
            if (!term) mval[w] = up ? mval[w] + 1 : mval[w] - 1;
            if (up ? mval[w] == 99 : mval[w] == 0) begin
              mst[w] = S_DONE;
              mco[w] = 1;
            end
          end
        end
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("w%0d digits", w), 32'(dg[w]), 32'(to_bcd(mval[w])));
      check($sformatf("w%0d running", w), 32'(rn[w]), 32'(mst[w] == S_RUN));
      check($sformatf("w%0d expired", w), 32'(ex[w]), 32'(mst[w] == S_DONE));
      check($sformatf("w%0d tick", w), 32'(tk[w]), 32'(mtk[w]));
      check($sformatf("w%0d carry", w), 32'(co[w]), 32'(mco[w]));
    end
    reset = 0; start = 0; stop = 0; clear = 0; load = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  initial begin
    for (int w = 0; w < 2; w++) begin
      mst[w] = S_IDLE; mval[w] = 0; mpre[w] = 0;
    end
    reset = 1; cyc();
    check("rst digits", 32'(dg[0]), 32'h00);
    check("rst running", 32'(rn[0]), 0);
    check("rst tick", 32'(tk[0]), 0);
    up = 1; start = 1; cyc();
    check("start running", 32'(rn[0]), 1);
    idle(3);
    check("first step", 32'(dg[0]), 32'h01);
    up = 0; clear = 1; cyc();
    load = 1; load_value = 8'h05; cyc();
    start = 1; cyc();
    idle(3);
    check("down 04", 32'(dg[0]), 32'h04);
    idle(12);
    check("down 00", 32'(dg[0]), 32'h00);
    check("down carry", 32'(co[0]), 1);
    check("down tick", 32'(tk[0]), 1);
    check("down expired", 32'(ex[0]), 1);
    check("down stopped", 32'(rn[0]), 0);
    start = 1; cyc();
    check("done start", 32'(ex[0]), 1);
    load = 1; load_value = 8'h03; cyc();
    check("load exits done", 32'(ex[0]), 0);
    up = 1; clear = 1; cyc();
    load = 1; load_value = 8'h98; cyc();
    start = 1; cyc();
    idle(3);
    check("up 99", 32'(dg[1]), 32'h99);
    idle(3);
    check("wrap 00", 32'(dg[1]), 32'h00);
    check("wrap carry", 32'(co[1]), 1);
    check("wrap running", 32'(rn[1]), 1);
    clear = 1; cyc();
    load = 1; load_value = 8'h09; cyc();
    start = 1; cyc();
    idle(3);
    check("ripple 10", 32'(dg[0]), 32'h10);
    up = 0; load = 1; load_value = 8'h10; cyc();
    idle(3);
    check("borrow 09", 32'(dg[0]), 32'h09);
    load = 1; load_value = 8'hA7; cyc();
    check("sat A7", 32'(dg[0]), 32'h97);
    load = 1; load_value = 8'hFF; cyc();
    check("sat FF", 32'(dg[0]), 32'h99);
    up = 1; clear = 1; cyc();
    start = 1; cyc();
    idle(1);
    stop = 1; cyc();
    check("paused", 32'(rn[0]), 0);
    idle(4);
    start = 1; cyc();
    idle(1);
    check("resume early", 32'(tk[0]), 0);
    idle(1);
    check("resume tick", 32'(tk[0]), 1);
    check("resume digits", 32'(dg[0]), 32'h01);
    stop = 1; clear = 1; cyc();
    check("stop+clear", 32'(dg[0]), 32'h00);
    start = 1; cyc();
    idle(2);
    load = 1; load_value = 8'h42; cyc();
    check("load on step tick", 32'(tk[0]), 0);
    check("load on step digits", 32'(dg[0]), 32'h42);
    idle(2);
    check("load restart early", 32'(tk[0]), 0);
    idle(1);
    check("load restart tick", 32'(tk[0]), 1);
    check("load restart digits", 32'(dg[0]), 32'h43);
    idle(2);
    reset = 1; cyc();
    check("reset on step tick", 32'(tk[0]), 0);
    check("reset on step digits", 32'(dg[0]), 32'h00);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 200) == 0;
      start = ($urandom % 8) == 0;
      stop = ($urandom % 14) == 0;
      clear = ($urandom % 60) == 0;
      load = ($urandom % 25) == 0;
      load_value = 8'($urandom);
      if (($urandom % 16) == 0) up = ~up;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Run-control sequencer for a multi-digit cascaded BCD counter, used as a stopwatch / countdown timer core. Owns the digit registers, a clock prescaler that paces count steps, and a command state machine (start, stop, clear, load) with up/down direction. Generates digit-to-digit carry/borrow ripple internally, and flags terminal-count events to the surrounding system.

## Interface
- DIGITS, 4, number of BCD digits (≥1); digit 0 is least significant, in bits [3:0].
- PRESCALE, 10, clk cycles per count step (≥1).
- WRAP, 0, 1 = wrap at terminal count and keep running; 0 = stop at terminal count.

- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command: begin/resume counting.
- stop  input  1  command: pause counting.
- clear  input  1  command: zero digits, go idle.
- load  input  1  command: load digits from load_value.
- load_value  input  4*DIGITS  preset value, one BCD nibble per digit.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on step cycles.
- digits  output  4*DIGITS  current count, registered.
- running  output  1  high while in RUN.
- tick  output  1  one-cycle pulse on each count-step edge.
- carry_out  output  1  one-cycle pulse on terminal-count event.
- expired  output  1  level, high in DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE. running = (state == RUN). expired = (state == DONE).
- Reset: state IDLE, digits all 0, prescaler 0, tick/carry_out/running/expired 0.
- Command priority per cycle: clear > load > stop > start. Only the highest-priority asserted command acts.
- clear (any state): digits ← 0, prescaler ← 0, state ← IDLE.
- load (any state): digits ← load_value, with any nibble > 9 saturated to 9. Prescaler ← 0. RUN stays RUN; PAUSED stays PAUSED; IDLE and DONE go to IDLE.
- stop: RUN → PAUSED, prescaler holds its value. Ignored in other states.
- start: IDLE or PAUSED → RUN. Ignored in RUN and DONE; DONE exits only via clear, load or reset.
- RUN prescaler:
  - Counts 0..PRESCALE-1.
  - The cycle where it equals PRESCALE-1 and no command is asserted is a step cycle. On that edge the prescaler returns to 0 and tick = 1.
- Step arithmetic, per digit:
  - up: digit i increments iff all lower digits == 9; 9 → 0.
  - down: digit i decrements iff all lower digits == 0; 0 → 9.
- Terminal value: all digits 9 (up) or all digits 0 (down), judged with the current up.
- WRAP=1: a step from the terminal value wraps to all 0 (up) or all 9 (down), with carry_out = 1 on that edge. State stays RUN.
- WRAP=0:
  - If the current value is terminal, the step leaves digits unchanged.
  - Otherwise the counter steps normally.
  - If the post-step value is terminal: state ← DONE, carry_out = 1 on that edge.
- Changing up mid-run takes effect on the next step cycle; no glitch in digits.
- A command on a would-be step cycle suppresses that step. A stop in that cycle holds the prescaler at PRESCALE-1, so the step occurs on the first RUN cycle after resume.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Command latency: state/digits update on the same edge that samples the command.
- start sampled at edge k: running = 1 after edge k. First tick and digit change at edge k+PRESCALE, then every PRESCALE cycles.
- PRESCALE=1: a step on every RUN cycle without a command.
- tick and carry_out are high for exactly one cycle. carry_out coincides with tick.
- Reset asserted mid-run takes priority over all commands and returns all outputs to reset values after that edge.

## Test plan
Bench: DIGITS=2, PRESCALE=3.
- Reset / idle:
  - reset high for one edge from arbitrary state → digits=0x00, running=0, expired=0, tick=0, carry_out=0.
  - Then start with no load, up=1 → running=1; digits=0x01 three cycles later.
- Countdown (WRAP=0):
  - load 0x05, up=0, start at edge k → digits 04,03,02,01,00 at k+3..k+15.
  - At k+15: carry_out and tick pulse, expired=1, running=0.
  - A later start → no change.
  - load 0x03 → IDLE, expired=0.
- Up wrap (WRAP=1): load 0x98, up=1, start → 99 at k+3; 00 at k+6 with carry_out=1; running stays 1.
- Ripple and saturation:
  - load 0x09 up → 10.
  - load 0x10 down → 09.
  - load_value 0xA7 → digits 0x97.
  - load_value 0xFF → 0x99.
- Pause / resume:
  - stop asserted one cycle after start → PAUSED, digits unchanged.
  - start 5 cycles later → first step 2 cycles after resume edge (prescaler retained).
  - stop and clear in the same cycle → IDLE, digits 0x00.
- Step suppression:
  - load asserted on a step cycle during RUN → digits = load value, no tick, prescaler restarts (next tick 3 cycles later).
  - Reset asserted on a step cycle → no tick, all outputs 0.
